sram_port_arbiter: RTL and testbench
====================================

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, access-phase length in mclk cycles (legal range 1..15).
REQ-002 mclk  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 a_begin_wr, a_begin_rd  in  1  port A (SPI, high priority) single-cycle request strobes.
REQ-005 a_addr  in  20  port A byte address; a_data_wr  in  8  port A write byte.
REQ-006 a_finish  out  1  port A completion pulse; a_data_rd  out  8  port A read byte.
REQ-007 b_begin_wr, b_begin_rd, b_addr, b_data_wr, b_finish, b_data_rd: port B (serial, low priority), same widths and meaning as port A.
REQ-008 sram_a  out  18  word address; sram_oe, sram_we  out  1  active-low, shared by both chips.
REQ-009 sram1_io, sram2_io  inout  16  chip data buses; sram1_ce/ub/lb, sram2_ce/ub/lb  out  1  active-low.

Function
REQ-010 Address mapping: addr[19] selects the chip (0 = sram1), addr[18:1] drives sram_a, addr[0] selects the lane (0 = lb/io[7:0], 1 = ub/io[15:8]).
REQ-011 Each port has one request slot; a begin strobe captures addr, data and direction into it when the slot is empty.
REQ-012 A begin strobe arriving while that port's slot is occupied (pending or in service) is dropped without side effect.
REQ-013 begin_wr and begin_rd asserted together on the same port is treated as a read.
REQ-014 States: IDLE, SETUP, ACCESS, FINISH.
REQ-015 Transitions: IDLE->SETUP when any request is pending or strobing; SETUP->ACCESS; ACCESS->FINISH after WAIT_CYCLES cycles; FINISH->SETUP if another request is pending, else IDLE.
REQ-016 Grant: port A wins whenever both ports are pending at a grant decision; no preemption of an access in progress.
REQ-017 Grant bypass: a strobe seen in IDLE is granted at that same edge, so SETUP is the next cycle.
REQ-018 Latency: begin in cycle 0 gives finish in cycle 2+WAIT_CYCLES (cycle 4 at default).
REQ-019 sram_a, the selected ce and the selected ub/lb are valid from SETUP through FINISH; all other ce/ub/lb stay high.
REQ-020 Read: sram_oe is low in SETUP and ACCESS; the lane byte is registered into data_rd at the last ACCESS edge.
REQ-021 Write: the FPGA drives data_wr on the selected lane of the selected chip from SETUP through FINISH; sram_we is low only during ACCESS.
REQ-022 Buses are high-Z in IDLE and for all reads; the unselected chip bus is always high-Z.
REQ-023 The served port's finish pulses high for exactly the FINISH cycle; its slot frees on that edge, so a begin in the finish cycle is accepted.
REQ-024 data_rd holds its value until that port's next read completes; writes never alter data_rd.
REQ-025 All sram_* outputs and finish are registered; no glitches are permitted on sram_we.

Reset
REQ-026 Reset forces: state IDLE, both slots empty, sram_oe/we/ce/ub/lb = 1, sram_a = 0, buses high-Z, finish = 0, data_rd = 0.
REQ-027 Reset during an access aborts it; no finish pulse is issued for the aborted request, and sram_we rises asynchronously.

Structure
REQ-028 Package sram_arb_pkg holds the state encoding, the WAIT_CYCLES default and the address field bit positions (chip, word, lane).
REQ-029 One sub-module, sram_req_slot, implements the per-port capture/pending/drop logic and is instantiated twice.

Verification
REQ-030 A write 0x5A to 0x00001, then an A read of 0x00001: sram1 ub/io[15:8] used, we low exactly 2 cycles, a_finish in cycle 4, a_data_rd = 0x5A.
REQ-031 B write 0xC3 to 0x80000, then a B read of it: sram2_ce low, sram1_ce high throughout, b_data_rd = 0xC3.
REQ-032 A and B reads strobed in the same cycle: A served first (finish cycle 4), B served immediately after (finish cycle 8), no IDLE cycle between them.
REQ-033 A second a_begin_rd during A's SETUP: the strobe is dropped and exactly one a_finish pulse occurs.
REQ-034 Reset asserted in the second ACCESS cycle of a write: sram_we is high immediately, no finish pulse occurs, and a subsequent read of that address returns a value (the memory content is not checked).
REQ-035 WAIT_CYCLES = 5 run: a_finish 7 cycles after the strobe, and sram_oe low for 6 cycles.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: FSM encoding,
// access-phase default and byte-address field positions.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_FINISH
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_t;

  localparam int WAIT_CYCLES_DEFAULT = 2;

  localparam int ADDR_W   = 20;
  localparam int WORD_W   = 18;
  localparam int CHIP_BIT = 19;
  localparam int WORD_MSB = 18;
  localparam int WORD_LSB = 1;
  localparam int LANE_BIT = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              rd;
  } req_t;

endpackage

// File: rtl/sram_req_slot.sv
// One-deep request slot for a single port: captures a begin strobe when empty,
// drops strobes while occupied, and frees on the served request's finish edge.
module sram_req_slot
  import sram_arb_pkg::*;
(
  input  logic              mclk,
  input  logic              reset,
  input  logic              begin_wr,
  input  logic              begin_rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_wr,
  input  logic              free,
  output logic              valid,
  output logic              req_now,
  output req_t              req
);

  logic strobe;
  logic accept;
  req_t held;

  assign strobe = begin_wr | begin_rd;
  // A strobe in the finish cycle lands in the slot being freed at that edge.
  assign accept = strobe && (!valid || free);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (accept) begin
      valid <= 1'b1;
      held  <= req_t'{addr: addr, data: data_wr, rd: begin_rd};
    end else if (free) begin
      valid <= 1'b0;
    end
  end

  // Combined view lets the arbiter grant a fresh strobe in the same cycle.
  assign req_now = valid | strobe;
  assign req     = valid ? held : req_t'{addr: addr, data: data_wr, rd: begin_rd};

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates byte accesses from two ports (A high priority) onto two shared
// 16-bit asynchronous SRAM chips; all SRAM controls and finish are registered.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              a_begin_wr,
  input  logic              a_begin_rd,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_data_wr,
  output logic              a_finish,
  output logic [7:0]        a_data_rd,
  input  logic              b_begin_wr,
  input  logic              b_begin_rd,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_data_wr,
  output logic              b_finish,
  output logic [7:0]        b_data_rd,
  output logic [WORD_W-1:0] sram_a,
  output logic              sram_oe,
  output logic              sram_we,
  inout  wire  [15:0]       sram1_io,
  inout  wire  [15:0]       sram2_io,
  output logic              sram1_ce,
  output logic              sram1_ub,
  output logic              sram1_lb,
  output logic              sram2_ce,
  output logic              sram2_ub,
  output logic              sram2_lb
);

  state_t state, state_d;
  port_t  cur_port, cur_port_d, grant_port;
  req_t   cur, cur_d, a_req, b_req;
  logic [3:0] cnt;
  logic a_valid, b_valid, a_req_now, b_req_now, a_free, b_free;
  logic pend_a, pend_b, grant, last_access;
  logic drv, drv_d;
  logic [7:0] wdata, rd_byte;
  logic active, chip2, lane_hi;
  logic [WORD_W-1:0] sram_a_d;
  logic oe_d, we_d, ce1_d, ub1_d, lb1_d, ce2_d, ub2_d, lb2_d, a_fin_d, b_fin_d;

  assign a_free = (state == ST_FINISH) && (cur_port == PORT_A);
  assign b_free = (state == ST_FINISH) && (cur_port == PORT_B);

  sram_req_slot u_slot_a (
    .mclk(mclk), .reset(reset), .begin_wr(a_begin_wr), .begin_rd(a_begin_rd),
    .addr(a_addr), .data_wr(a_data_wr), .free(a_free),
    .valid(a_valid), .req_now(a_req_now), .req(a_req)
  );

  sram_req_slot u_slot_b (
    .mclk(mclk), .reset(reset), .begin_wr(b_begin_wr), .begin_rd(b_begin_rd),
    .addr(b_addr), .data_wr(b_data_wr), .free(b_free),
    .valid(b_valid), .req_now(b_req_now), .req(b_req)
  );

  // Grant decisions happen only in IDLE (strobe bypass) and FINISH (other port).
  assign pend_a = (state == ST_IDLE) ? a_req_now
                                     : (state == ST_FINISH) && (cur_port == PORT_B) && a_valid;
  assign pend_b = (state == ST_IDLE) ? b_req_now
                                     : (state == ST_FINISH) && (cur_port == PORT_A) && b_valid;
  assign grant       = pend_a | pend_b;
  assign grant_port  = pend_a ? PORT_A : PORT_B;
  assign cur_d       = grant ? ((grant_port == PORT_A) ? a_req : b_req) : cur;
  assign cur_port_d  = grant ? grant_port : cur_port;
  assign last_access = (state == ST_ACCESS) && (cnt == 4'(WAIT_CYCLES - 1));

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur      <= '0;
      cur_port <= PORT_A;
    end else begin
      state    <= state_d;
      cnt      <= (state == ST_ACCESS) ? cnt + 4'd1 : 4'd0;
      cur      <= cur_d;
      cur_port <= cur_port_d;
    end
  end

  // NOTE: the default at the top of each always_comb keeps every path assigned,
  // so no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:   if (grant) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (last_access) state_d = ST_FINISH;
      ST_FINISH: state_d = grant ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state and registered, keeping sram_we glitch-free.
  always_comb begin
    active   = (state_d != ST_IDLE);
    chip2    = cur_d.addr[CHIP_BIT];
    lane_hi  = cur_d.addr[LANE_BIT];
    sram_a_d = active ? cur_d.addr[WORD_MSB:WORD_LSB] : '0;
    ce1_d    = !(active && !chip2);
    ub1_d    = !(active && !chip2 && lane_hi);
    lb1_d    = !(active && !chip2 && !lane_hi);
    ce2_d    = !(active && chip2);
    ub2_d    = !(active && chip2 && lane_hi);
    lb2_d    = !(active && chip2 && !lane_hi);
    oe_d     = !(active && cur_d.rd && (state_d != ST_FINISH));
    we_d     = !((state_d == ST_ACCESS) && !cur_d.rd);
    drv_d    = active && !cur_d.rd;
    a_fin_d  = (state_d == ST_FINISH) && (cur_port_d == PORT_A);
    b_fin_d  = (state_d == ST_FINISH) && (cur_port_d == PORT_B);
  end

  always_comb begin
    rd_byte = 8'h00;
    unique case ({cur.addr[CHIP_BIT], cur.addr[LANE_BIT]})
      2'b00:   rd_byte = sram1_io[7:0];
      2'b01:   rd_byte = sram1_io[15:8];
      2'b10:   rd_byte = sram2_io[7:0];
      default: rd_byte = sram2_io[15:8];
    endcase
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sram_a    <= '0;
      sram_oe   <= 1'b1;
      sram_we   <= 1'b1;
      sram1_ce  <= 1'b1;
      sram1_ub  <= 1'b1;
      sram1_lb  <= 1'b1;
      sram2_ce  <= 1'b1;
      sram2_ub  <= 1'b1;
      sram2_lb  <= 1'b1;
      drv       <= 1'b0;
      wdata     <= '0;
      a_finish  <= 1'b0;
      b_finish  <= 1'b0;
      a_data_rd <= '0;
      b_data_rd <= '0;
    end else begin
      sram_a   <= sram_a_d;
      sram_oe  <= oe_d;
      sram_we  <= we_d;
      sram1_ce <= ce1_d;
      sram1_ub <= ub1_d;
      sram1_lb <= lb1_d;
      sram2_ce <= ce2_d;
      sram2_ub <= ub2_d;
      sram2_lb <= lb2_d;
      drv      <= drv_d;
      wdata    <= cur_d.data;
      a_finish <= a_fin_d;
      b_finish <= b_fin_d;
      if (last_access && cur.rd) begin
        if (cur_port == PORT_A) a_data_rd <= rd_byte;
        else                    b_data_rd <= rd_byte;
      end
    end
  end

  // The lane strobes already encode chip and lane selection.
  assign sram1_io[7:0]  = (drv && !sram1_lb) ? wdata : 8'bz;
  assign sram1_io[15:8] = (drv && !sram1_ub) ? wdata : 8'bz;
  assign sram2_io[7:0]  = (drv && !sram2_lb) ? wdata : 8'bz;
  assign sram2_io[15:8] = (drv && !sram2_ub) ? wdata : 8'bz;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: default-parameter arbiter with two behavioural SRAMs, plus a
// WAIT_CYCLES=5 instance for access-length timing.
module tb_sram_port_arbiter;

  logic mclk = 1'b0;
  logic reset;
  always #5 mclk = ~mclk;

  logic        a_begin_wr, a_begin_rd, b_begin_wr, b_begin_rd;
  logic [19:0] a_addr, b_addr;
  logic [7:0]  a_data_wr, b_data_wr;
  logic        a_finish, b_finish;
  logic [7:0]  a_data_rd, b_data_rd;
  logic [17:0] sram_a;
  logic        sram_oe, sram_we;
  wire  [15:0] sram1_io, sram2_io;
  logic        sram1_ce, sram1_ub, sram1_lb, sram2_ce, sram2_ub, sram2_lb;

  sram_port_arbiter dut (
    .mclk(mclk), .reset(reset),
    .a_begin_wr(a_begin_wr), .a_begin_rd(a_begin_rd), .a_addr(a_addr), .a_data_wr(a_data_wr),
    .a_finish(a_finish), .a_data_rd(a_data_rd),
    .b_begin_wr(b_begin_wr), .b_begin_rd(b_begin_rd), .b_addr(b_addr), .b_data_wr(b_data_wr),
    .b_finish(b_finish), .b_data_rd(b_data_rd),
    .sram_a(sram_a), .sram_oe(sram_oe), .sram_we(sram_we),
    .sram1_io(sram1_io), .sram2_io(sram2_io),
    .sram1_ce(sram1_ce), .sram1_ub(sram1_ub), .sram1_lb(sram1_lb),
    .sram2_ce(sram2_ce), .sram2_ub(sram2_ub), .sram2_lb(sram2_lb)
  );

  // Behavioural asynchronous SRAMs: read while ce/oe low, write on we rising.
  bit [15:0] mem1 [262144];
  bit [15:0] mem2 [262144];
  logic rd1, rd2;
  assign rd1 = !sram1_ce && !sram_oe && sram_we;
  assign rd2 = !sram2_ce && !sram_oe && sram_we;
  assign sram1_io[7:0]  = (rd1 && !sram1_lb) ? mem1[sram_a][7:0]  : 8'bz;
  assign sram1_io[15:8] = (rd1 && !sram1_ub) ? mem1[sram_a][15:8] : 8'bz;
  assign sram2_io[7:0]  = (rd2 && !sram2_lb) ? mem2[sram_a][7:0]  : 8'bz;
  assign sram2_io[15:8] = (rd2 && !sram2_ub) ? mem2[sram_a][15:8] : 8'bz;

  always @(posedge sram_we) begin
    if (!sram1_ce && !sram1_lb) mem1[sram_a][7:0]  <= sram1_io[7:0];
    if (!sram1_ce && !sram1_ub) mem1[sram_a][15:8] <= sram1_io[15:8];
    if (!sram2_ce && !sram2_lb) mem2[sram_a][7:0]  <= sram2_io[7:0];
    if (!sram2_ce && !sram2_ub) mem2[sram_a][15:8] <= sram2_io[15:8];
  end

  // Second instance with a longer access phase; chip 1 returns a fixed pattern.
  logic        w_begin_rd, w_zero;
  logic [19:0] w_addr, w_zero_addr;
  logic [7:0]  w_zero_data;
  logic        w_a_finish, w_b_finish, w_oe, w_we;
  logic [7:0]  w_a_data_rd, w_b_data_rd;
  logic [17:0] w_sram_a;
  wire  [15:0] w_io1, w_io2;
  logic        w_ce1, w_ub1, w_lb1, w_ce2, w_ub2, w_lb2;

  sram_port_arbiter #(.WAIT_CYCLES(5)) dut_w5 (
    .mclk(mclk), .reset(reset),
    .a_begin_wr(w_zero), .a_begin_rd(w_begin_rd), .a_addr(w_addr), .a_data_wr(w_zero_data),
    .a_finish(w_a_finish), .a_data_rd(w_a_data_rd),
    .b_begin_wr(w_zero), .b_begin_rd(w_zero), .b_addr(w_zero_addr), .b_data_wr(w_zero_data),
    .b_finish(w_b_finish), .b_data_rd(w_b_data_rd),
    .sram_a(w_sram_a), .sram_oe(w_oe), .sram_we(w_we),
    .sram1_io(w_io1), .sram2_io(w_io2),
    .sram1_ce(w_ce1), .sram1_ub(w_ub1), .sram1_lb(w_lb1),
    .sram2_ce(w_ce2), .sram2_ub(w_ub2), .sram2_lb(w_lb2)
  );

  assign w_io1[7:0]  = (!w_oe && !w_ce1 && !w_lb1) ? 8'h5A : 8'bz;
  assign w_io1[15:8] = (!w_oe && !w_ce1 && !w_ub1) ? 8'hA5 : 8'bz;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Per-transfer observations, collected at mid-cycle (negedge).
  int fin_a_cyc, fin_b_cyc, fin_a_cnt, fin_b_cnt, we_low, oe_low, ce1_low, ce2_low;
  logic [17:0] snap_a;
  logic        snap_ce1, snap_ub1, snap_lb1, snap_ce2, snap_lb2;
  logic [15:0] snap_io1, snap_io2;

  task automatic run_xfer(input logic do_a, input logic a_rd, input logic [19:0] aa,
                          input logic [7:0] ad, input logic do_b, input logic b_rd,
                          input logic [19:0] ba, input logic [7:0] bd,
                          input int extra_cyc, input logic [19:0] extra_addr, input int ncyc);
    fin_a_cyc = -1; fin_b_cyc = -1; fin_a_cnt = 0; fin_b_cnt = 0;
    we_low = 0; oe_low = 0; ce1_low = 0; ce2_low = 0;
    a_begin_rd = do_a && a_rd;  a_begin_wr = do_a && !a_rd;  a_addr = aa;  a_data_wr = ad;
    b_begin_rd = do_b && b_rd;  b_begin_wr = do_b && !b_rd;  b_addr = ba;  b_data_wr = bd;
    @(negedge mclk);
    a_begin_rd = 1'b0; a_begin_wr = 1'b0; b_begin_rd = 1'b0; b_begin_wr = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == 1) begin
        snap_a = sram_a; snap_ce1 = sram1_ce; snap_ub1 = sram1_ub; snap_lb1 = sram1_lb;
        snap_ce2 = sram2_ce; snap_lb2 = sram2_lb; snap_io1 = sram1_io; snap_io2 = sram2_io;
      end
      if (!sram_we)  we_low++;
      if (!sram_oe)  oe_low++;
      if (!sram1_ce) ce1_low++;
      if (!sram2_ce) ce2_low++;
      if (a_finish) begin fin_a_cnt++; if (fin_a_cyc < 0) fin_a_cyc = c; end
      if (b_finish) begin fin_b_cnt++; if (fin_b_cyc < 0) fin_b_cyc = c; end
      if (c == extra_cyc) begin a_begin_rd = 1'b1; a_addr = extra_addr; end
      else a_begin_rd = 1'b0;
      @(negedge mclk);
    end
    a_begin_rd = 1'b0;
  endtask

  int fin_cnt, fin_cyc, oe_cnt;

  initial begin
    reset = 1'b1;
    a_begin_wr = 0; a_begin_rd = 0; a_addr = '0; a_data_wr = '0;
    b_begin_wr = 0; b_begin_rd = 0; b_addr = '0; b_data_wr = '0;
    w_begin_rd = 0; w_zero = 0; w_addr = '0; w_zero_addr = '0; w_zero_data = '0;
    repeat (2) @(negedge mclk);

    check("rst_we", sram_we, 1);
    check("rst_oe", sram_oe, 1);
    check("rst_ce", {sram1_ce, sram1_ub, sram1_lb, sram2_ce, sram2_ub, sram2_lb}, 6'h3F);
    check("rst_addr", sram_a, 0);
    check("rst_finish", {a_finish, b_finish}, 0);
    check("rst_data_rd", {a_data_rd, b_data_rd}, 0);
    reset = 1'b0;
    @(negedge mclk);

    // A write 0x5A to byte 0x00001: chip 1, word 0, upper lane.
    run_xfer(1, 0, 20'h00001, 8'h5A, 0, 0, 0, 0, 0, 0, 6);
    check("wr1_lanes", {snap_ce1, snap_ub1, snap_lb1, snap_ce2}, 4'b0011);
    check("wr1_addr", snap_a, 0);
    check("wr1_io_hi", snap_io1[15:8], 8'h5A);
    check("wr1_we_low", we_low, 2);
    check("wr1_fin_cyc", fin_a_cyc, 4);
    check("wr1_fin_cnt", {fin_a_cnt[7:0], fin_b_cnt[7:0]}, 16'h0100);

    run_xfer(1, 1, 20'h00001, 8'h00, 0, 0, 0, 0, 0, 0, 6);
    check("rd1_fin_cyc", fin_a_cyc, 4);
    check("rd1_oe_low", oe_low, 3);
    check("rd1_we_low", we_low, 0);
    check("rd1_data", a_data_rd, 8'h5A);

    // A write 0xE7 to 0x2468A: word 0x12345, lower lane; B reads it back.
    run_xfer(1, 0, 20'h2468A, 8'hE7, 0, 0, 0, 0, 0, 0, 6);
    check("wr2_addr", snap_a, 18'h12345);
    check("wr2_lanes", {snap_ub1, snap_lb1}, 2'b10);
    check("wr2_io_lo", snap_io1[7:0], 8'hE7);
    check("wr2_keeps_rd", a_data_rd, 8'h5A);

    run_xfer(0, 0, 0, 0, 1, 1, 20'h2468A, 8'h00, 0, 0, 6);
    check("rd2_b_fin", fin_b_cyc, 4);
    check("rd2_a_quiet", fin_a_cnt, 0);
    check("rd2_b_data", b_data_rd, 8'hE7);

    // B write 0xC3 to 0x80000: chip 2 only.
    run_xfer(0, 0, 0, 0, 1, 0, 20'h80000, 8'hC3, 0, 0, 6);
    check("wr3_ce2_lb2", {snap_ce2, snap_lb2}, 2'b00);
    check("wr3_io2_lo", snap_io2[7:0], 8'hC3);
    check("wr3_ce1_low", ce1_low, 0);
    check("wr3_ce2_low", ce2_low, 4);
    check("wr3_b_fin", fin_b_cyc, 4);

    run_xfer(0, 0, 0, 0, 1, 1, 20'h80000, 8'h00, 0, 0, 6);
    check("rd3_ce1_low", ce1_low, 0);
    check("rd3_b_data", b_data_rd, 8'hC3);

    // Simultaneous reads: A first, B back-to-back.
    run_xfer(1, 1, 20'h00001, 8'h00, 1, 1, 20'h80000, 8'h00, 0, 0, 10);
    check("both_a_fin", fin_a_cyc, 4);
    check("both_b_fin", fin_b_cyc, 8);
    check("both_oe_low", oe_low, 6);
    check("both_a_data", a_data_rd, 8'h5A);
    check("both_b_data", b_data_rd, 8'hC3);

    // Second strobe during SETUP is dropped.
    run_xfer(1, 1, 20'h00001, 8'h00, 0, 0, 0, 0, 1, 20'h2468A, 12);
    check("drop_fin_cnt", fin_a_cnt, 1);
    check("drop_data", a_data_rd, 8'h5A);

    // Strobe in the FINISH cycle is accepted.
    run_xfer(1, 1, 20'h00001, 8'h00, 0, 0, 0, 0, 4, 20'h2468A, 14);
    check("fin_accept_cnt", fin_a_cnt, 2);
    check("fin_accept_data", a_data_rd, 8'hE7);

    // Reset in the second ACCESS cycle of a write aborts it.
    a_begin_wr = 1'b1; a_addr = 20'h00101; a_data_wr = 8'h77;
    @(negedge mclk);
    a_begin_wr = 1'b0;
    @(negedge mclk);
    check("abort_we_c2", sram_we, 0);
    @(negedge mclk);
    check("abort_we_c3", sram_we, 0);
    reset = 1'b1;
    #1;
    check("abort_we_async", sram_we, 1);
    check("abort_ce_async", sram1_ce, 1);
    fin_cnt = 0;
    repeat (2) begin
      @(negedge mclk);
      if (a_finish) fin_cnt++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge mclk);
      if (a_finish) fin_cnt++;
    end
    check("abort_no_fin", fin_cnt, 0);
    check("abort_rd_clr", a_data_rd, 0);
    run_xfer(1, 1, 20'h00101, 8'h00, 0, 0, 0, 0, 0, 0, 6);
    check("abort_rd_fin", fin_a_cyc, 4);

    // WAIT_CYCLES = 5 instance.
    w_begin_rd = 1'b1; w_addr = 20'h00000;
    @(negedge mclk);
    w_begin_rd = 1'b0;
    fin_cyc = -1; oe_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (!w_oe) oe_cnt++;
      if (w_a_finish && fin_cyc < 0) fin_cyc = c;
      @(negedge mclk);
    end
    check("w5_fin_cyc", fin_cyc, 7);
    check("w5_oe_low", oe_cnt, 6);
    check("w5_data", w_a_data_rd, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
